// File: rtl/cache_assoc_wb_if.sv
// Bus bundle for cache_assoc_wb: two read ports, one write port, eviction
// drain towards memory and the flush controls.
interface cache_assoc_wb_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] raddr0_;
    logic [DATA_WIDTH-1:0] rdata0_;
    logic                  rvalid0_;
    logic [ADDR_WIDTH-1:0] raddr1_;
    logic [DATA_WIDTH-1:0] rdata1_;
    logic                  rvalid1_;
    logic                  wen0;
    logic [ADDR_WIDTH-1:0] waddr0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic                  wready0;
    logic                  store_en;
    logic [ADDR_WIDTH-1:0] store_addr;
    logic [DATA_WIDTH-1:0] store_data;
    logic                  store_ready;
    logic                  flush_req;
    logic                  flush_busy;
    logic                  flush_done;

    modport master (
        output raddr0_, raddr1_, wen0, waddr0, wdata0, store_ready, flush_req,
        input  rdata0_, rvalid0_, rdata1_, rvalid1_, wready0,
               store_en, store_addr, store_data, flush_busy, flush_done
    );

    modport slave (
        input  raddr0_, raddr1_, wen0, waddr0, wdata0, store_ready, flush_req,
        output rdata0_, rvalid0_, rdata1_, rvalid1_, wready0,
               store_en, store_addr, store_data, flush_busy, flush_done
    );
endinterface

// File: rtl/cache_assoc_wb.sv
// 1- or 2-way set-associative write-allocate cache, one word per line, with a
// FIFO that drains evicted lines to memory and a walker that flushes all lines.
module cache_assoc_wb #(
    parameter int ADDR_WIDTH  = 15,
    parameter int DATA_WIDTH  = 16,
    parameter int INDEX_WIDTH = 6,
    parameter int WAYS        = 2,
    parameter int READ_DELAY  = 2,
    parameter int EVICT_DEPTH = 4
) (
    input logic             clk,
    input logic             reset,
    cache_assoc_wb_if.slave bus
);
    localparam int SETS      = 2 ** INDEX_WIDTH;
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;
    localparam int PIPE      = (READ_DELAY > 1) ? READ_DELAY - 1 : 1;
    localparam int PTR_W     = $clog2(EVICT_DEPTH);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t state_q, next_state;
    logic   flush_done_q, flush_done_d;

    logic [SETS-1:0]       valid_q [WAYS];
    logic [TAG_WIDTH-1:0]  tag_q   [WAYS][SETS];
    logic [DATA_WIDTH-1:0] data_q  [WAYS][SETS];
    logic [SETS-1:0]       lru_q;

    logic [ADDR_WIDTH-1:0] pipe0_q [PIPE];
    logic [ADDR_WIDTH-1:0] pipe1_q [PIPE];
    logic [ADDR_WIDTH-1:0] look0, look1;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q, hdata0, hdata1;
    logic                  rvalid0_q, rvalid1_q, hit0, hit1;

    logic [ADDR_WIDTH-1:0] fifo_addr_q [EVICT_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [EVICT_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]        count_q;
    logic                  fifo_full, push, pop;
    logic [ADDR_WIDTH-1:0] push_addr;
    logic [DATA_WIDTH-1:0] push_data;

    logic [INDEX_WIDTH-1:0] w_idx, ptr_idx_q;
    logic [TAG_WIDTH-1:0]   w_tag;
    logic                   w_hit, w_hit_way, victim, w_way, w_fire, wready, evict_push;
    logic                   ptr_way_q, fl_valid, fl_push, fl_advance, fl_last;

    // Hit flag and data for one address against the current (pre-edge) arrays.
    function automatic logic [DATA_WIDTH:0] lookup(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH:0] r;
        r = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][a[INDEX_WIDTH-1:0]] &&
                tag_q[w][a[INDEX_WIDTH-1:0]] == a[ADDR_WIDTH-1:INDEX_WIDTH]) begin
                r = {1'b1, data_q[w][a[INDEX_WIDTH-1:0]]};
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE; i++) begin
                pipe0_q[i] <= '0;
                pipe1_q[i] <= '0;
            end
        end else begin
            pipe0_q[0] <= bus.raddr0_;
            pipe1_q[0] <= bus.raddr1_;
            for (int i = 1; i < PIPE; i++) begin
                pipe0_q[i] <= pipe0_q[i-1];
                pipe1_q[i] <= pipe1_q[i-1];
            end
        end
    end

    always_comb begin
        look0 = (READ_DELAY > 1) ? pipe0_q[PIPE-1] : bus.raddr0_;
        look1 = (READ_DELAY > 1) ? pipe1_q[PIPE-1] : bus.raddr1_;
        {hit0, hdata0} = lookup(look0);
        {hit1, hdata1} = lookup(look1);
    end

    // A miss leaves the previous read data in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= hit0;
            rvalid1_q <= hit1;
            if (hit0) rdata0_q <= hdata0;
            if (hit1) rdata1_q <= hdata1;
        end
    end

    always_comb begin
        w_idx     = bus.waddr0[INDEX_WIDTH-1:0];
        w_tag     = bus.waddr0[ADDR_WIDTH-1:INDEX_WIDTH];
        w_hit     = 1'b0;
        w_hit_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][w_idx] && tag_q[w][w_idx] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = 1'(w);
            end
        end
        // Prefer an empty way; only fall back to LRU when the set is full.
        if (WAYS == 1)                   victim = 1'b0;
        else if (!valid_q[0][w_idx])     victim = 1'b0;
        else if (!valid_q[WAYS-1][w_idx]) victim = 1'b1;
        else                             victim = lru_q[w_idx];
        w_way      = w_hit ? w_hit_way : victim;
        fifo_full  = (count_q == (PTR_W+1)'(EVICT_DEPTH));
        wready     = (state_q == IDLE) && !fifo_full;
        w_fire     = bus.wen0 && wready;
        evict_push = w_fire && !w_hit && valid_q[victim][w_idx];
    end

    always_comb begin
        fl_valid   = valid_q[ptr_way_q][ptr_idx_q];
        fl_push    = (state_q == FLUSH) && fl_valid && !fifo_full;
        fl_advance = (state_q == FLUSH) && (!fl_valid || !fifo_full);
        fl_last    = (ptr_idx_q == INDEX_WIDTH'(SETS-1)) && (ptr_way_q == 1'(WAYS-1));
        push       = evict_push || fl_push;
        if (fl_push) begin
            push_addr = {tag_q[ptr_way_q][ptr_idx_q], ptr_idx_q};
            push_data = data_q[ptr_way_q][ptr_idx_q];
        end else begin
            push_addr = {tag_q[victim][w_idx], w_idx};
            push_data = data_q[victim][w_idx];
        end
        pop = (count_q != '0) && bus.store_ready;
    end

    always_comb begin
        next_state   = state_q;
        flush_done_d = 1'b0;
        case (state_q)
            IDLE:  if (bus.flush_req) next_state = FLUSH;
            FLUSH: if (fl_advance && fl_last) begin
                       next_state   = IDLE;
                       flush_done_d = 1'b1;
                   end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= next_state;
            flush_done_q <= flush_done_d;
        end
    end

    // Walk order: ways of a set first, then the next set.
    always_ff @(posedge clk) begin
        if (reset || (state_q == IDLE && bus.flush_req)) begin
            ptr_idx_q <= '0;
            ptr_way_q <= 1'b0;
        end else if (fl_advance) begin
            if (ptr_way_q == 1'(WAYS-1)) begin
                ptr_way_q <= 1'b0;
                ptr_idx_q <= ptr_idx_q + 1'b1;
            end else begin
                ptr_way_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            lru_q <= '0;
        end else begin
            if (w_fire) begin
                valid_q[w_way][w_idx] <= 1'b1;
                if (WAYS > 1) lru_q[w_idx] <= ~w_way;
            end
            if (fl_push) valid_q[ptr_way_q][ptr_idx_q] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            tag_q[w_way][w_idx]  <= w_tag;
            data_q[w_way][w_idx] <= bus.wdata0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= push_addr;
            fifo_data_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    assign bus.rdata0_    = rdata0_q;
    assign bus.rvalid0_   = rvalid0_q;
    assign bus.rdata1_    = rdata1_q;
    assign bus.rvalid1_   = rvalid1_q;
    assign bus.wready0    = wready;
    assign bus.store_en   = (count_q != '0);
    assign bus.store_addr = fifo_addr_q[rd_ptr_q];
    assign bus.store_data = fifo_data_q[rd_ptr_q];
    assign bus.flush_busy = (state_q == FLUSH);
    assign bus.flush_done = flush_done_q;
endmodule

// File: tb/tb_cache_assoc_wb.sv
// Directed self-checking bench for cache_assoc_wb (2 ways, 64 sets, read delay 2,
// 4-entry eviction FIFO); inputs change on negedge, outputs checked on negedge.
module tb_cache_assoc_wb;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cache_assoc_wb_if #(.ADDR_WIDTH(15), .DATA_WIDTH(16)) bus ();

    cache_assoc_wb #(
        .ADDR_WIDTH(15), .DATA_WIDTH(16), .INDEX_WIDTH(6),
        .WAYS(2), .READ_DELAY(2), .EVICT_DEPTH(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic do_reset();
        reset = 1'b1;
        bus.wen0 = 1'b0;
        bus.flush_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_write(input logic [14:0] a, input logic [15:0] d);
        bus.wen0   = 1'b1;
        bus.waddr0 = a;
        bus.wdata0 = d;
        @(negedge clk);
        bus.wen0 = 1'b0;
    endtask

    task automatic read2(input logic [14:0] a0, input logic [14:0] a1);
        bus.raddr0_ = a0;
        bus.raddr1_ = a1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        read2(15'h0010, 15'h0010);
        checks++; if (bus.rvalid0_ !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid0: got %b want 0", bus.rvalid0_); end
        checks++; if (bus.rdata0_ !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rdata0: got %h want 0000", bus.rdata0_); end
        checks++; if (bus.store_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_store_en: got %b want 0", bus.store_en); end
        checks++; if (bus.wready0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_wready0: got %b want 1", bus.wready0); end
        checks++; if (bus.flush_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush_busy: got %b want 0", bus.flush_busy); end
        checks++; if (bus.flush_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush_done: got %b want 0", bus.flush_done); end
    endtask

    task automatic test_write_hit();
        do_write(15'h0123, 16'hBEEF);
        read2(15'h0123, 15'h0123);
        checks++; if (bus.rvalid0_ !== 1'b1) begin errors++; $display("[TB] FAIL hit_rvalid0: got %b want 1", bus.rvalid0_); end
        checks++; if (bus.rdata0_ !== 16'hBEEF) begin errors++; $display("[TB] FAIL hit_rdata0: got %h want beef", bus.rdata0_); end
        checks++; if (bus.rvalid1_ !== 1'b1) begin errors++; $display("[TB] FAIL hit_rvalid1: got %b want 1", bus.rvalid1_); end
        checks++; if (bus.rdata1_ !== 16'hBEEF) begin errors++; $display("[TB] FAIL hit_rdata1: got %h want beef", bus.rdata1_); end
        // Same set, different tag: miss must keep the old data.
        read2(15'h0223, 15'h0123);
        checks++; if (bus.rvalid0_ !== 1'b0) begin errors++; $display("[TB] FAIL miss_rvalid0: got %b want 0", bus.rvalid0_); end
        checks++; if (bus.rdata0_ !== 16'hBEEF) begin errors++; $display("[TB] FAIL miss_hold_rdata0: got %h want beef", bus.rdata0_); end
    endtask

    task automatic test_evict_lru();
        do_reset();
        bus.store_ready = 1'b0;
        do_write(15'h0005, 16'h1111);
        do_write(15'h0045, 16'h2222);
        checks++; if (bus.store_en !== 1'b0) begin errors++; $display("[TB] FAIL evict_none_yet: got %b want 0", bus.store_en); end
        do_write(15'h0085, 16'h3333);
        checks++; if (bus.store_en !== 1'b1) begin errors++; $display("[TB] FAIL evict_store_en: got %b want 1", bus.store_en); end
        checks++; if (bus.store_addr !== 15'h0005) begin errors++; $display("[TB] FAIL evict_store_addr: got %h want 0005", bus.store_addr); end
        checks++; if (bus.store_data !== 16'h1111) begin errors++; $display("[TB] FAIL evict_store_data: got %h want 1111", bus.store_data); end
        read2(15'h0045, 15'h0085);
        checks++; if (bus.rvalid0_ !== 1'b1 || bus.rdata0_ !== 16'h2222) begin errors++; $display("[TB] FAIL evict_read_0045: got %b/%h want 1/2222", bus.rvalid0_, bus.rdata0_); end
        checks++; if (bus.rvalid1_ !== 1'b1 || bus.rdata1_ !== 16'h3333) begin errors++; $display("[TB] FAIL evict_read_0085: got %b/%h want 1/3333", bus.rvalid1_, bus.rdata1_); end
        read2(15'h0005, 15'h0085);
        checks++; if (bus.rvalid0_ !== 1'b0) begin errors++; $display("[TB] FAIL evict_read_0005: got %b want 0", bus.rvalid0_); end
    endtask

    task automatic test_fifo_backpressure();
        logic [14:0] exp_addr [4];
        logic [15:0] exp_data [4];
        exp_addr[0] = 15'h0007; exp_data[0] = 16'hA001;
        exp_addr[1] = 15'h0047; exp_data[1] = 16'hA002;
        exp_addr[2] = 15'h0087; exp_data[2] = 16'hA003;
        exp_addr[3] = 15'h00C7; exp_data[3] = 16'hA004;
        do_reset();
        bus.store_ready = 1'b0;
        do_write(15'h0007, 16'hA001);
        do_write(15'h0047, 16'hA002);
        do_write(15'h0087, 16'hA003);
        do_write(15'h00C7, 16'hA004);
        do_write(15'h0107, 16'hA005);
        checks++; if (bus.wready0 !== 1'b1) begin errors++; $display("[TB] FAIL bp_wready_3: got %b want 1", bus.wready0); end
        do_write(15'h0147, 16'hA006);
        checks++; if (bus.wready0 !== 1'b0) begin errors++; $display("[TB] FAIL bp_wready_full: got %b want 0", bus.wready0); end
        bus.store_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.store_en !== 1'b1 || bus.store_addr !== exp_addr[i] || bus.store_data !== exp_data[i]) begin
                errors++; $display("[TB] FAIL bp_pop%0d: got en=%b %h/%h want en=1 %h/%h", i, bus.store_en, bus.store_addr, bus.store_data, exp_addr[i], exp_data[i]);
            end
            @(negedge clk);
            if (i == 0) begin
                checks++; if (bus.wready0 !== 1'b1) begin errors++; $display("[TB] FAIL bp_wready_after_pop: got %b want 1", bus.wready0); end
            end
        end
        checks++; if (bus.store_en !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained: got %b want 0", bus.store_en); end
    endtask

    task automatic test_flush();
        logic [14:0] got [8];
        int n = 0;
        int dones = 0;
        int post = 0;
        do_reset();
        bus.store_ready = 1'b1;
        do_write(15'h0002, 16'h5002);
        do_write(15'h0001, 16'h5001);
        do_write(15'h0041, 16'h5041);
        bus.flush_req = 1'b1;
        @(negedge clk);
        bus.flush_req = 1'b0;
        checks++; if (bus.flush_busy !== 1'b1) begin errors++; $display("[TB] FAIL flush_busy: got %b want 1", bus.flush_busy); end
        checks++; if (bus.wready0 !== 1'b0) begin errors++; $display("[TB] FAIL flush_wready: got %b want 0", bus.wready0); end
        for (int c = 0; c < 300; c++) begin
            if (bus.store_en === 1'b1) begin
                if (n < 8) got[n] = bus.store_addr;
                n++;
            end
            if (bus.flush_done === 1'b1) dones++;
            if (dones > 0) begin
                if (post >= 4) break;
                post++;
            end
            @(negedge clk);
        end
        checks++; if (dones != 1) begin errors++; $display("[TB] FAIL flush_done_pulses: got %0d want 1", dones); end
        checks++; if (n != 3) begin errors++; $display("[TB] FAIL flush_evict_count: got %0d want 3", n); end
        if (n >= 3) begin
            checks++; if (got[0] !== 15'h0001 || got[1] !== 15'h0041 || got[2] !== 15'h0002) begin
                errors++; $display("[TB] FAIL flush_order: got %h %h %h want 0001 0041 0002", got[0], got[1], got[2]);
            end
        end
        checks++; if (bus.flush_busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle: got %b want 0", bus.flush_busy); end
        read2(15'h0001, 15'h0041);
        checks++; if (bus.rvalid0_ !== 1'b0 || bus.rvalid1_ !== 1'b0) begin errors++; $display("[TB] FAIL flush_read_miss: got %b%b want 00", bus.rvalid0_, bus.rvalid1_); end
        read2(15'h0002, 15'h0002);
        checks++; if (bus.rvalid0_ !== 1'b0) begin errors++; $display("[TB] FAIL flush_read_0002: got %b want 0", bus.rvalid0_); end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        bus.store_ready = 1'b0;
        do_write(15'h0000, 16'h6000);
        do_write(15'h0040, 16'h6040);
        do_write(15'h0001, 16'h6001);
        bus.flush_req = 1'b1;
        @(negedge clk);
        bus.flush_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.store_en !== 1'b1 || bus.flush_busy !== 1'b1) begin errors++; $display("[TB] FAIL midflush_state: got en=%b busy=%b want 1 1", bus.store_en, bus.flush_busy); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.flush_busy !== 1'b0) begin errors++; $display("[TB] FAIL midflush_busy: got %b want 0", bus.flush_busy); end
        checks++; if (bus.store_en !== 1'b0) begin errors++; $display("[TB] FAIL midflush_store_en: got %b want 0", bus.store_en); end
        checks++; if (bus.flush_done !== 1'b0) begin errors++; $display("[TB] FAIL midflush_done: got %b want 0", bus.flush_done); end
        reset = 1'b0;
        read2(15'h0001, 15'h0040);
        checks++; if (bus.rvalid0_ !== 1'b0 || bus.rvalid1_ !== 1'b0) begin errors++; $display("[TB] FAIL midflush_read_miss: got %b%b want 00", bus.rvalid0_, bus.rvalid1_); end
    endtask

    initial begin
        bus.raddr0_     = '0;
        bus.raddr1_     = '0;
        bus.wen0        = 1'b0;
        bus.waddr0      = '0;
        bus.wdata0      = '0;
        bus.store_ready = 1'b0;
        bus.flush_req   = 1'b0;
        @(negedge clk);
        test_reset();
        test_write_hit();
        test_evict_lru();
        test_fifo_backpressure();
        test_flush();
        test_reset_mid_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
